// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The memory answers the address presented this cycle and qualifies the word with imem_ready.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, fetches from instruction memory, and turns execute-stage redirects into bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [1:0]           PCSrc,
  input  logic [31:0]          PC_target,
  input  logic [31:0]          aluResult,
  input  logic                 jalr,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic                 flush_ex
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    redirect        = (PCSrc != 2'b00);
    redirect_target = PC_target;
    if (PCSrc[1] && jalr) begin
      // JALR clears bit 0 of the computed address.
      redirect_target = aluResult & 32'hFFFF_FFFE;
    end
  end

  // Modulo-2^32 add: a fetch at 32'hFFFF_FFFC continues at 0.
  assign pc_plus4       = pc + 32'd4;
  assign flush_ex       = redirect & ~rst;
  assign imem.imem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      state       <= BOOT;
    end else if (redirect) begin
      // Wrong-path fetch is dropped, even if the memory is answering right now.
      pc          <= redirect_target;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      state       <= RUN;
    end else if (!stall) begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, MEMWAIT: begin
          if (imem.imem_ready) begin
            if_id_instr <= imem.imem_rdata;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
            state       <= RUN;
          end else begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            state       <= MEMWAIT;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a driver steps a spec-level model and queues expectations;
// a monitor pops one expectation after every clock edge and compares it with the DUT outputs.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [31:0] PC_target;
  logic [31:0] aluResult;
  logic        jalr;
  logic        ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        flush_ex;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .PC_target   (PC_target),
    .aluResult   (aluResult),
    .jalr        (jalr),
    .imem        (bus.master),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .flush_ex    (flush_ex)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word at 0, a distinct hash everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);
  assign bus.imem_ready = ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] addr;
    logic        flush;
    logic        chk_pc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural PC, "still booting" flag, and the IF/ID contents.
  logic [31:0] m_pc;
  logic        m_booting;
  logic [31:0] m_instr, m_ifpc, m_ifpc4;
  logic        m_valid;
  logic        m_after_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_bubble();
    m_instr = NOP_INSTR;
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
    m_ifpc4 = 32'h0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, and queue what the DUT must show.
  task automatic cycle(input logic r, input logic s, input logic [1:0] src,
                       input logic [31:0] tgt, input logic [31:0] alu,
                       input logic j, input logic rdy);
    exp_t e;
    logic [31:0] target;
    logic        redir;
    @(negedge clk);
    rst = r; stall = s; PCSrc = src; PC_target = tgt; aluResult = alu; jalr = j; ready = rdy;

    redir  = (src != 2'b00);
    target = (src >= 2'd2 && j) ? alu - (alu % 2) : tgt;
    e.flush = redir && !r;
    m_after_rst = 1'b0;
    if (r) begin
      m_pc = RESET_PC; m_booting = 1'b1; model_bubble(); m_after_rst = 1'b1;
    end else if (redir) begin
      m_pc = target; m_booting = 1'b0; model_bubble();
    end else if (s) begin
      // everything holds
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (rdy) begin
      m_instr = mem_word(m_pc);
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end else begin
      model_bubble();
    end

    e.instr  = m_instr;
    e.pc     = m_ifpc;
    e.pc4    = m_ifpc4;
    e.valid  = m_valid;
    e.addr   = m_pc;
    e.chk_pc = m_valid || m_after_rst;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, rdy);
  endtask

  task automatic jump_to(input logic [31:0] t);
    cycle(1'b0, 1'b0, 2'b01, t, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: inputs change only on the falling edge, so flush_ex still reflects the pre-edge inputs here.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("flush_ex",    {31'h0, flush_ex},    {31'h0, mon_e.flush});
      check("imem_addr",   bus.imem_addr,        mon_e.addr);
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, mon_e.valid});
      check("if_id_instr", if_id_instr,          mon_e.instr);
      if (mon_e.chk_pc) begin
        check("if_id_pc",  if_id_pc,  mon_e.pc);
        check("if_id_pc4", if_id_pc4, mon_e.pc4);
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; PCSrc = 2'b00; PC_target = '0; aluResult = '0; jalr = 1'b0; ready = 1'b1;
    m_pc = RESET_PC; m_booting = 1'b1; m_after_rst = 1'b1;
    m_instr = NOP_INSTR; m_ifpc = '0; m_ifpc4 = '0; m_valid = 1'b0;

    // Reset, BOOT, then sequential fetch of 0,4,8,12.
    cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Branch taken at PC=0x10, then fetch from 0x40.
    jump_to(32'h40);
    idle(2, 1'b1);

    // JALR redirect beats stall and a missing memory response; then a normal fetch proves RUN.
    cycle(1'b0, 1'b1, 2'b10, 32'hDEAD_BEE0, 32'h0000_0123, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Jump without jalr uses PC_target.
    cycle(1'b0, 1'b0, 2'b11, 32'h0000_001C, 32'h0000_0555, 1'b0, 1'b1);
    idle(1, 1'b1);
    // PC is now 0x20: stall three cycles, then release.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Memory wait at PC=0x8.
    jump_to(32'h4);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Wrap-around at the top of the address space, and a misaligned target passed through.
    jump_to(32'hFFFF_FFFC);
    idle(2, 1'b1);
    jump_to(32'h0000_0102);
    idle(1, 1'b1);

    // Mid-operation reset with a redirect pending: reset wins, flush_ex stays low.
    cycle(1'b1, 1'b1, 2'b01, 32'h0000_0800, 32'h0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      t = $urandom();
      if ($urandom_range(0, 9) != 0) t = t & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            t, $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC register and drives the instruction-memory address.
- Consumes the redirect outputs of the execute (ALU) stage: PCSrc, PC_target and aluResult.
- Feeds the decode stage the fetched instruction, its PC and PC+4; flushes wrong-path instructions on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word inserted as a bubble (ADDI x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall: hold PC and IF/ID
- PCSrc  in  2  from execute: 00 sequential, 01 branch taken, 1x jump
- PC_target  in  32  execute-stage PC+imm (branch/JAL target)
- aluResult  in  32  execute-stage ALU result (JALR target)
- jalr  in  1  qualifies jump: 1 selects aluResult, 0 selects PC_target
- imem_addr  out  32  instruction address (= PC, combinational)
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory returns data for imem_addr this cycle
- if_id_instr  out  32  registered instruction to decode
- if_id_pc  out  32  registered PC of if_id_instr
- if_id_pc4  out  32  registered PC+4
- if_id_valid  out  1  1 = if_id_instr is a real instruction
- flush_ex  out  1  combinational: clear ID/EX register (redirect taken)

Behaviour:
- Reset (rst=1 at edge): PC=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc4=0; if_id_valid=0; state=BOOT. flush_ex is 0 while rst=1. Reset mid-operation discards everything, including pending redirects.
- FSM states:
  - BOOT: one cycle, no fetch; imem_addr=PC. Next state is RUN.
  - RUN: normal fetch.
  - MEMWAIT: entered from RUN when imem_ready=0 with no stall and no redirect. Stays until imem_ready=1.
- Redirect = (PCSrc!=00), evaluated every cycle, highest priority in all states except during reset.
- Redirect target:
  - PCSrc=01: PC_target.
  - PCSrc=1x and jalr=1: {aluResult[31:1],1'b0}.
  - PCSrc=1x and jalr=0: PC_target.
- Priority per edge: rst > redirect > stall > imem_ready.
  - Redirect: PC<=target; IF/ID<=bubble (NOP_INSTR, valid 0); flush_ex=1 this cycle; state<=RUN. This applies even if stall=1 or imem_ready=0; the current memory response is discarded.
  - Stall (no redirect): PC and all IF/ID outputs hold; state holds.
  - RUN/MEMWAIT with imem_ready=1: IF/ID<={imem_rdata, PC, PC+4, valid 1}; PC<=PC+4; state<=RUN.
  - RUN/MEMWAIT with imem_ready=0: PC holds; IF/ID<=bubble; state<=MEMWAIT.
  - BOOT: IF/ID stays bubble; PC holds.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. No misalignment trap. PC[1:0] always 00 except a PC_target misaligned by upstream, which is passed through unchanged.
- Latency: an instruction appears on if_id_* one edge after its address is on imem_addr with imem_ready=1. The first valid instruction appears 2 edges after rst deasserts (BOOT + fetch).
- flush_ex = redirect & ~rst. No registered copy.

Test Plan:
- Reset release, imem_ready=1, imem_rdata=32'h00500093 at addr 0 -> edge1 BOOT, edge2 if_id_instr=32'h00500093, if_id_pc=0, if_id_pc4=4, valid=1, PC=4.
- Sequential fetch of 4 words at 0,4,8,12 -> if_id_pc steps 0,4,8,12 on consecutive edges, valid stays 1.
- PCSrc=01, PC_target=32'h40 while PC=0x10 -> flush_ex=1 that cycle; next edge PC=0x40, if_id_instr=32'h00000013, valid=0. Following edge fetches 0x40.
- PCSrc=10, jalr=1, aluResult=32'h0000_0123 together with stall=1 and imem_ready=0 -> redirect wins: PC=32'h122, IF/ID bubble, FSM=RUN.
- stall=1 for 3 cycles at PC=0x20 -> PC and if_id_* unchanged for 3 edges. On release, if_id_pc=0x20 captured next edge.
- imem_ready=0 for 2 cycles at PC=0x8, then 1 -> two bubbles (valid=0) in MEMWAIT; third edge if_id_pc=0x8, valid=1, PC=0xC. Also: PC=32'hFFFFFFFC fetch -> PC wraps to 0.
